// File: rtl/iobus_timer_pkg.sv
// iobus_timer_pkg: register offsets, CTRL bit indices, FSM state type
// and the address-decode helper shared by the timer block.
package iobus_timer_pkg;

   localparam logic [4:0] OFF_CTRL     = 5'h00;
   localparam logic [4:0] OFF_LOAD     = 5'h04;
   localparam logic [4:0] OFF_COUNT    = 5'h08;
   localparam logic [4:0] OFF_STATUS   = 5'h0C;
   localparam logic [4:0] OFF_PRESCALE = 5'h10;

   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Word-granular match: byte lane bits [1:0] never take part.
   function automatic logic addr_hit(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [4:0]  off
   );
      logic [31:0] a;
      a = base + {27'd0, off};
      return addr[31:2] == a[31:2];
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 16-bit divider; tick is high on the cycle the count
// equals limit while enabled, then the count restarts from 0.
// Ports: clk, rst_n (sync, active low), clr, en, limit[15:0] -> tick.
// Only instantiated when IOBUS_TIMER_PRESCALE_EN is defined.
module timer_prescaler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [15:0] limit,
   output logic        tick
);

   logic [15:0] cnt;

   assign tick = en && (cnt == limit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? 16'd0 : cnt + 16'd1;
      end
   end

endmodule

// File: rtl/iobus_timer.sv
// iobus_timer: memory-mapped down-counting timer with one-shot or
// auto-reload mode and a level interrupt.
// Ports: CLK, RESET_N (sync, active low), IOBUS_ADDR/OUT/WR (MCU store
// side), IOBUS_IN (registered read data), INTR (PENDING & CTRL.IE).
// Define IOBUS_TIMER_PRESCALE_EN to add the PRESCALE register and the
// timer_prescaler divider; otherwise the counter ticks every RUN cycle.
module iobus_timer
   import iobus_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   output logic        INTR
);

   state_t      state, state_n;
   logic [2:0]  ctrl, ctrl_n;
   logic [31:0] load, count, rd_data, pres_rd;
   logic        pending, tick;
   logic        start, dec, expire, reload;

   logic sel_ctrl, sel_load, sel_count, sel_status, sel_pres;
   logic wr_ctrl, wr_load, wr_count, wr_status;

   assign sel_ctrl   = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_CTRL);
   assign sel_load   = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_LOAD);
   assign sel_count  = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_COUNT);
   assign sel_status = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_STATUS);
   assign sel_pres   = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_PRESCALE);

   assign wr_ctrl   = IOBUS_WR & sel_ctrl;
   assign wr_load   = IOBUS_WR & sel_load;
   assign wr_count  = IOBUS_WR & sel_count;
   assign wr_status = IOBUS_WR & sel_status;

`ifdef IOBUS_TIMER_PRESCALE_EN
   logic [15:0] prescale;
   logic        wr_pres;

   assign wr_pres = IOBUS_WR & sel_pres;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         prescale <= '0;
      end else if (wr_pres) begin
         prescale <= IOBUS_OUT[15:0];
      end
   end

   timer_prescaler u_pre (
      .clk   (CLK),
      .rst_n (RESET_N),
      .clr   (start),
      .en    (state == RUN),
      .limit (prescale),
      .tick  (tick)
   );

   assign pres_rd = {16'd0, prescale};
`else
   assign tick    = 1'b1;
   assign pres_rd = '0;
`endif

   // A CTRL write clearing EN pre-empts any tick in the same cycle.
   always_comb begin
      state_n = state;
      start   = 1'b0;
      dec     = 1'b0;
      expire  = 1'b0;
      reload  = 1'b0;
      unique case (state)
         RUN: begin
            if (wr_ctrl && !IOBUS_OUT[CTRL_EN]) begin
               state_n = IDLE;
            end else if (tick) begin
               if (count != '0) begin
                  dec = 1'b1;
               end else begin
                  expire = 1'b1;
                  if (ctrl[CTRL_AR]) reload = 1'b1;
                  else state_n = DONE;
               end
            end
         end
         default: begin
            if (wr_ctrl) begin
               start   = IOBUS_OUT[CTRL_EN];
               state_n = IOBUS_OUT[CTRL_EN] ? RUN : IDLE;
            end
         end
      endcase
   end

   always_comb begin
      ctrl_n = ctrl;
      if (wr_ctrl) ctrl_n = IOBUS_OUT[2:0];
      if (expire && !reload) ctrl_n[CTRL_EN] = 1'b0;
   end

   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         sel_ctrl:   rd_data = {29'd0, ctrl};
         sel_load:   rd_data = load;
         sel_count:  rd_data = count;
         sel_status: rd_data = {31'd0, pending};
         sel_pres:   rd_data = pres_rd;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state    <= IDLE;
         ctrl     <= '0;
         load     <= '0;
         count    <= '0;
         pending  <= 1'b0;
         IOBUS_IN <= '0;
      end else begin
         state    <= state_n;
         ctrl     <= ctrl_n;
         IOBUS_IN <= rd_data;
         if (wr_load) load <= IOBUS_OUT;
         // A bus write to COUNT beats reload/decrement on a tick edge.
         if (start)         count <= load;
         else if (wr_count) count <= IOBUS_OUT;
         else if (reload)   count <= load;
         else if (dec)      count <= count - 32'd1;
         // Expiry beats a simultaneous W1C so no event is lost.
         if (expire)                        pending <= 1'b1;
         else if (wr_status && IOBUS_OUT[0]) pending <= 1'b0;
      end
   end

   assign INTR = pending & ctrl[CTRL_IE];

endmodule

// File: doc/iobus_timer.md
IOBUS_TIMER -- requirements
Module: iobus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1100_0200, byte address of register block (word-aligned, 32-byte window).
REQ-002 Port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port RESET_N  input  1  synchronous, active-low reset.
REQ-004 Port IOBUS_ADDR  input  32  byte address driven by MCU.
REQ-005 Port IOBUS_OUT  input  32  write data driven by MCU.
REQ-006 Port IOBUS_WR  input  1  write strobe, one cycle per store.
REQ-007 Port IOBUS_IN  output  32  registered read data to MCU.
REQ-008 Port INTR  output  1  level interrupt request to MCU.

Function
REQ-009 Register map (offset from BASE_ADDR, bits [1:0] ignored): 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS, 0x10 PRESCALE; full 32-bit compare on bits [31:2].
REQ-010 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IE; bits [31:3] read 0, writes ignored.
REQ-011 LOAD: 32-bit reload value, R/W.
REQ-012 COUNT: 32-bit down-counter; read returns current value; a write loads COUNT directly.
REQ-013 STATUS: bit0 PENDING; reads return PENDING; writing 1 to bit0 clears it; writing 0 has no effect.
REQ-014 PRESCALE: bits [15:0] R/W; bits [31:16] read 0.
REQ-015 Write takes effect at the edge where IOBUS_WR=1 and address matches; visible on IOBUS_IN from the following cycle.
REQ-016 IOBUS_IN registered: each edge loads the value of the register addressed by current IOBUS_ADDR; unmapped address loads 0; one-cycle read latency.
REQ-017 Writes to unmapped addresses are ignored with no side effects.
REQ-018 State machine states IDLE, RUN, DONE.
REQ-019 IDLE/DONE -> RUN on CTRL write setting EN=1: COUNT <= LOAD, prescaler cleared, same edge.
REQ-020 Any state -> IDLE on CTRL write with EN=0; COUNT holds value.
REQ-021 In RUN, tick when prescaler counter == PRESCALE, then prescaler counter <= 0; otherwise prescaler counter increments; PRESCALE=0 gives tick every cycle.
REQ-022 On tick with COUNT != 0: COUNT <= COUNT - 1.
REQ-023 On tick with COUNT == 0: PENDING <= 1; if AUTO_RELOAD, COUNT <= LOAD and stay RUN; else CTRL.EN <= 0, go DONE, COUNT holds 0.
REQ-024 Expiry period = (LOAD+1)*(PRESCALE+1) cycles; LOAD=0 with AUTO_RELOAD expires every tick.
REQ-025 Bus write to COUNT in same cycle as tick: write wins, no decrement.
REQ-026 STATUS clear in same cycle as expiry: set wins, PENDING stays 1.
REQ-027 CTRL write keeping EN=1 while RUN changes AUTO_RELOAD/IE only; no reload.
REQ-028 INTR = PENDING & CTRL.IE, combinational from registers, no glitch source from bus inputs.
REQ-029 Counter arithmetic unsigned 32-bit; no wrap below 0.

Reset
REQ-030 On RESET_N=0 at an edge: state IDLE, CTRL=0, LOAD=0, COUNT=0, PENDING=0, PRESCALE=0, prescaler counter=0, IOBUS_IN=0, INTR=0.
REQ-031 Reset mid-RUN aborts count at that edge; pending interrupt lost.

Configuration
REQ-032 Macro IOBUS_TIMER_PRESCALE_EN: when defined, prescaler and PRESCALE register per REQ-014/021.
REQ-033 When undefined: tick every RUN cycle, PRESCALE reads 0, writes to 0x10 ignored, no prescaler flops.

Structure
REQ-034 Package iobus_timer_pkg holds register offset constants, CTRL bit index constants, and state enum typedef.
REQ-035 One sub-module timer_prescaler (16-bit counter, clear, enable, tick out), instantiated only under IOBUS_TIMER_PRESCALE_EN.

Verification
REQ-036 Reset: hold RESET_N=0 two cycles -> all registers read 0, INTR=0.
REQ-037 One-shot: LOAD=3, PRESCALE=0, CTRL=0x5 -> PENDING and INTR rise 4 cycles after CTRL write edge, state DONE, CTRL reads 0x4, COUNT=0.
REQ-038 Auto-reload+prescale: LOAD=1, PRESCALE=2, CTRL=0x7 -> PENDING set every 6 cycles; W1C STATUS=1 clears INTR next cycle.
REQ-039 Collision: STATUS write 1 on the exact expiry edge -> PENDING remains 1; COUNT write 0x10 on tick edge -> COUNT reads 0x10.
REQ-040 Bus: write 0xDEAD to BASE_ADDR+0x20 -> no register changes, read returns 0; read of LOAD returns value one cycle after address.
REQ-041 Abort: RESET_N=0 while RUN with COUNT=5 -> next cycle state IDLE, COUNT=0, INTR=0.
